// File: rtl/dual_port_ram_param.sv
// rtl/dual_port_ram_param.sv - parametrised true dual-port RAM with byte lanes,
// selectable read latency, deterministic same-address arbitration and collision counting.
module dual_port_ram_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cs_0,
   input  logic                    wr_0,
   input  logic                    oe_0,
   input  logic [DATA_WIDTH/8-1:0] be_0,
   input  logic [ADDR_WIDTH-1:0]   addr_0,
   input  logic [DATA_WIDTH-1:0]   wdata_0,
   output logic [DATA_WIDTH-1:0]   rdata_0,
   output logic                    rvalid_0,
   input  logic                    cs_1,
   input  logic                    wr_1,
   input  logic                    oe_1,
   input  logic [DATA_WIDTH/8-1:0] be_1,
   input  logic [ADDR_WIDTH-1:0]   addr_1,
   input  logic [DATA_WIDTH-1:0]   wdata_1,
   output logic [DATA_WIDTH-1:0]   rdata_1,
   output logic                    rvalid_1,
   output logic                    collision,
   output logic [CNT_WIDTH-1:0]    coll_count
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   generate
      if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
         $error("dual_port_ram_param: RD_LATENCY must be 1 or 2");
      end
      if (DATA_WIDTH % 8 != 0) begin : g_bad_width
         $error("dual_port_ram_param: DATA_WIDTH must be a multiple of 8");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic we_0, we_1, re_0, re_1, same_addr, coll_hit;
   logic [DATA_WIDTH-1:0] rword_0, rword_1;

   assign we_0      = cs_0 && wr_0;
   assign we_1      = cs_1 && wr_1;
   assign re_0      = cs_0 && !wr_0 && oe_0;
   assign re_1      = cs_1 && !wr_1 && oe_1;
   assign same_addr = (addr_0 == addr_1);
   assign coll_hit  = we_0 && we_1 && same_addr && (|(be_0 & be_1));

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [LANES-1:0]      lanes
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

   // Port 0 is assigned last, so it owns any lane both ports write at one address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) begin
            if (we_1 && be_1[i]) mem[addr_1][8*i +: 8] <= wdata_1[8*i +: 8];
            if (we_0 && be_0[i]) mem[addr_0][8*i +: 8] <= wdata_0[8*i +: 8];
         end
      end
   end

   // A reading port is never writing, so only the opposite port can alter the word.
   always_comb begin
      rword_0 = mem[addr_0];
      rword_1 = mem[addr_1];
      if (RDW_MODE != 0) begin
         if (we_1 && same_addr) rword_0 = merge_lanes(mem[addr_0], wdata_1, be_1);
         if (we_0 && same_addr) rword_1 = merge_lanes(mem[addr_1], wdata_0, be_0);
      end
   end

   logic                  s1_valid_0, s1_valid_1;
   logic [DATA_WIDTH-1:0] s1_data_0, s1_data_1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_0 <= 1'b0;
         s1_valid_1 <= 1'b0;
         s1_data_0  <= '0;
         s1_data_1  <= '0;
      end else begin
         s1_valid_0 <= re_0;
         s1_valid_1 <= re_1;
         s1_data_0  <= re_0 ? rword_0 : '0;
         s1_data_1  <= re_1 ? rword_1 : '0;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_valid_0, s2_valid_1;
         logic [DATA_WIDTH-1:0] s2_data_0, s2_data_1;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_valid_0 <= 1'b0;
               s2_valid_1 <= 1'b0;
               s2_data_0  <= '0;
               s2_data_1  <= '0;
            end else begin
               s2_valid_0 <= s1_valid_0;
               s2_valid_1 <= s1_valid_1;
               s2_data_0  <= s1_data_0;
               s2_data_1  <= s1_data_1;
            end
         end

         assign rvalid_0 = s2_valid_0;
         assign rvalid_1 = s2_valid_1;
         assign rdata_0  = s2_data_0;
         assign rdata_1  = s2_data_1;
      end else begin : g_lat1
         assign rvalid_0 = s1_valid_0;
         assign rvalid_1 = s1_valid_1;
         assign rdata_0  = s1_data_0;
         assign rdata_1  = s1_data_1;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collision  <= 1'b0;
         coll_count <= '0;
      end else begin
         collision <= coll_hit;
         if (coll_hit && (coll_count != {CNT_WIDTH{1'b1}})) begin
            coll_count <= coll_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb/tb_dual_port_ram_param.sv - scoreboard bench driving a read-first latency-1 and
// a write-first latency-2 instance from shared stimulus against a word-level model.
module tb_dual_port_ram_param;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int CW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          cs_0 = 0, wr_0 = 0, oe_0 = 0, cs_1 = 0, wr_1 = 0, oe_1 = 0;
   logic [3:0]    be_0 = 0, be_1 = 0;
   logic [AW-1:0] addr_0 = 0, addr_1 = 0;
   logic [DW-1:0] wdata_0 = 0, wdata_1 = 0;

   logic [DW-1:0] rd_a0, rd_a1, rd_b0, rd_b1;
   logic          rv_a0, rv_a1, rv_b0, rv_b1, coll_a, coll_b;
   logic [CW-1:0] cnt_a, cnt_b;

   dual_port_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0), .CNT_WIDTH(CW)) u_a (
      .clk(clk), .rst(rst),
      .cs_0(cs_0), .wr_0(wr_0), .oe_0(oe_0), .be_0(be_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .rdata_0(rd_a0), .rvalid_0(rv_a0),
      .cs_1(cs_1), .wr_1(wr_1), .oe_1(oe_1), .be_1(be_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .rdata_1(rd_a1), .rvalid_1(rv_a1),
      .collision(coll_a), .coll_count(cnt_a));

   dual_port_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1), .CNT_WIDTH(CW)) u_b (
      .clk(clk), .rst(rst),
      .cs_0(cs_0), .wr_0(wr_0), .oe_0(oe_0), .be_0(be_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .rdata_0(rd_b0), .rvalid_0(rv_b0),
      .cs_1(cs_1), .wr_1(wr_1), .oe_1(oe_1), .be_1(be_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .rdata_1(rd_b1), .rvalid_1(rv_b1),
      .collision(coll_b), .coll_count(cnt_b));

   typedef struct { logic [31:0] data; int edge_n; } rd_t;
   typedef struct { int edge_n; logic coll; int cnt; } cl_t;

   rd_t         rq [4][$];
   cl_t         cq [$];
   logic [31:0] model [64];
   int          cnt_model = 0;
   int          cyc = 0;
   int          cmps = 0;
   int          errs = 0;

   logic [3:0]  rv_v;
   logic [31:0] rd_v [4];
   assign rv_v  = {rv_b1, rv_b0, rv_a1, rv_a0};
   assign rd_v[0] = rd_a0;
   assign rd_v[1] = rd_a1;
   assign rd_v[2] = rd_b0;
   assign rd_v[3] = rd_b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmps++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word seen at address a once this edge's writes land: port 0 owns shared lanes.
   function automatic logic [31:0] after_write(input logic [5:0] a);
      logic [31:0] w;
      w = model[a];
      for (int i = 0; i < 4; i++) begin
         if (cs_0 && wr_0 && addr_0 == a && be_0[i]) w[8*i +: 8] = wdata_0[8*i +: 8];
         else if (cs_1 && wr_1 && addr_1 == a && be_1[i]) w[8*i +: 8] = wdata_1[8*i +: 8];
      end
      return w;
   endfunction

   task automatic step(input logic c0, input logic w0, input logic o0, input logic [3:0] b0,
                       input logic [5:0] a0, input logic [31:0] d0,
                       input logic c1, input logic w1, input logic o1, input logic [3:0] b1,
                       input logic [5:0] a1, input logic [31:0] d1);
      int          e;
      logic        hit;
      logic [31:0] n0, n1;
      @(negedge clk);
      cs_0 = c0; wr_0 = w0; oe_0 = o0; be_0 = b0; addr_0 = a0; wdata_0 = d0;
      cs_1 = c1; wr_1 = w1; oe_1 = o1; be_1 = b1; addr_1 = a1; wdata_1 = d1;
      e = cyc + 1;
      if (rst) begin
         cnt_model = 0;
         cq.push_back('{e, 1'b0, 0});
      end else begin
         hit = c0 && w0 && c1 && w1 && (a0 == a1) && ((b0 & b1) != 4'h0);
         if (hit && cnt_model < 255) cnt_model++;
         cq.push_back('{e, hit, cnt_model});
         if (c0 && !w0 && o0) begin
            rq[0].push_back('{model[a0], e});
            rq[2].push_back('{after_write(a0), e + 1});
         end
         if (c1 && !w1 && o1) begin
            rq[1].push_back('{model[a1], e});
            rq[3].push_back('{after_write(a1), e + 1});
         end
         n0 = after_write(a0);
         n1 = after_write(a1);
         if (c0 && w0) model[a0] = n0;
         if (c1 && w1) model[a1] = n1;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 0, 0, 0, 4'h0, 6'd0, 32'h0);
   endtask

   always begin : monitor
      rd_t t;
      cl_t c;
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 4; k++) begin
         if (rv_v[k]) begin
            if (rq[k].size() == 0) begin
               cmps++; errs++;
               $display("FAIL rvalid_unexpected[%0d]: got rvalid=1, expected 0 (cycle %0d)", k, cyc);
            end else begin
               t = rq[k].pop_front();
               chk($sformatf("rdata[%0d]", k), rd_v[k], t.data);
               chk($sformatf("rvalid_cycle[%0d]", k), cyc, t.edge_n);
            end
         end else begin
            chk($sformatf("rdata_idle[%0d]", k), rd_v[k], 32'h0);
            if (rq[k].size() > 0 && rq[k][0].edge_n <= cyc) begin
               t = rq[k].pop_front();
               cmps++; errs++;
               $display("FAIL rvalid_missing[%0d]: got rvalid=0, expected data %0h (cycle %0d)", k, t.data, cyc);
            end
         end
      end
      while (cq.size() > 0 && cq[0].edge_n < cyc) c = cq.pop_front();
      if (cq.size() > 0 && cq[0].edge_n == cyc) begin
         c = cq.pop_front();
         chk("collision_a", {31'h0, coll_a}, {31'h0, c.coll});
         chk("collision_b", {31'h0, coll_b}, {31'h0, c.coll});
         chk("coll_count_a", 32'(cnt_a), 32'(c.cnt));
         chk("coll_count_b", 32'(cnt_b), 32'(c.cnt));
      end
   end

   initial begin
      // Reset then idle.
      repeat (3) idle();
      rst = 1'b0;
      #1;
      chk("reset_rvalid_a0", {31'h0, rv_a0}, 32'h0);
      chk("reset_rvalid_b1", {31'h0, rv_b1}, 32'h0);
      chk("reset_rdata_b0", rd_b0, 32'h0);
      chk("reset_count_a", 32'(cnt_a), 32'h0);

      for (int i = 0; i < 32; i++) begin
         step(1, 1, 0, 4'hF, 6'(2 * i), $urandom, 1, 1, 0, 4'hF, 6'(2 * i + 1), $urandom);
      end

      // Byte-lane writes then cross-port read.
      step(1, 1, 0, 4'hF, 6'd5, 32'hAABBCCDD, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      step(1, 1, 0, 4'h5, 6'd5, 32'h11223344, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 0, 1, 4'h0, 6'd5, 32'h0);
      repeat (2) idle();

      // Pipelined back-to-back reads.
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 1, 0, 4'hF, 6'd1, 32'h10);
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 1, 0, 4'hF, 6'd2, 32'h20);
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 1, 0, 4'hF, 6'd3, 32'h30);
      step(1, 0, 1, 4'h0, 6'd1, 32'h0, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      step(1, 0, 1, 4'h0, 6'd2, 32'h0, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      step(1, 0, 1, 4'h0, 6'd3, 32'h0, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      repeat (3) idle();

      // Single write/write collision then read-back.
      step(1, 1, 0, 4'h3, 6'd9, 32'h000000FF, 1, 1, 0, 4'hF, 6'd9, 32'hFFFF0000);
      step(1, 0, 1, 4'h0, 6'd9, 32'h0, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      idle();
      chk("coll_count_single", 32'(cnt_a), 32'd1);
      repeat (2) idle();

      // Read-during-write across ports.
      step(1, 1, 0, 4'hF, 6'd7, 32'h12345678, 0, 0, 0, 4'h0, 6'd0, 32'h0);
      step(1, 0, 1, 4'h0, 6'd7, 32'h0, 1, 1, 0, 4'hF, 6'd7, 32'hCAFEBABE);
      repeat (3) idle();

      // Random traffic on a narrow address window so conflicts are frequent.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, $urandom_range(0, 1) == 1, ($urandom % 4) != 0,
              4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), $urandom,
              ($urandom % 4) != 0, $urandom_range(0, 1) == 1, ($urandom % 4) != 0,
              4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), $urandom);
      end
      repeat (3) idle();

      // Counter saturation.
      for (int i = 0; i < 300; i++) begin
         step(1, 1, 0, 4'h3, 6'd9, 32'h000000FF, 1, 1, 0, 4'hF, 6'd9, 32'hFFFF0000);
      end
      repeat (2) idle();
      chk("coll_count_sat_a", 32'(cnt_a), 32'd255);
      chk("coll_count_sat_b", 32'(cnt_b), 32'd255);

      // Reset mid-read, plus a write attempted while reset is held.
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 0, 1, 4'h0, 6'd3, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      cnt_model = 0;
      #1;
      chk("midreset_rvalid_b1", {31'h0, rv_b1}, 32'h0);
      chk("midreset_rdata_b1", rd_b1, 32'h0);
      chk("midreset_rvalid_a1", {31'h0, rv_a1}, 32'h0);
      chk("midreset_count_b", 32'(cnt_b), 32'h0);
      for (int k = 0; k < 4; k++) rq[k].delete();
      step(1, 1, 0, 4'hF, 6'd3, 32'hDEADBEEF, 1, 1, 0, 4'hF, 6'd4, 32'h0BADF00D);
      step(0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 0, 1, 4'h0, 6'd3, 32'h0);
      idle();
      rst = 1'b0;
      repeat (4) idle();
      step(1, 0, 1, 4'h0, 6'd3, 32'h0, 1, 0, 1, 4'h0, 6'd4, 32'h0);
      step(1, 0, 1, 4'h0, 6'd4, 32'h0, 1, 0, 1, 4'h0, 6'd4, 32'h0);
      repeat (4) idle();

      for (int k = 0; k < 4; k++) chk($sformatf("queue_drained[%0d]", k), 32'(rq[k].size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
- Parametrised synchronous true dual-port RAM; next generation of the team's fixed-size dual-port RAM.
- Adds separate read/write data buses, byte-lane write enables and selectable read latency (1 or 2 cycles) with read-valid strobes.
- Adds deterministic same-address arbitration, a read-during-write mode and a collision counter.
- Sits between two independent masters, such as a CPU-side port and a DMA-side port, sharing one storage array.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH words.
- RD_LATENCY, 1, read latency in cycles; only 1 or 2 is legal, any other value is an elaboration error.
- RDW_MODE, 0, cross-port read-during-write result: 0 = read-first (old data), 1 = write-first (new merged data).
- CNT_WIDTH, 8, width of the saturating collision counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs_0  in  1  port 0 chip select.
- wr_0  in  1  port 0 write (1) / read (0).
- oe_0  in  1  port 0 output enable; a read is issued only when high.
- be_0  in  DATA_WIDTH/8  port 0 byte-lane write enables.
- addr_0  in  ADDR_WIDTH  port 0 address.
- wdata_0  in  DATA_WIDTH  port 0 write data.
- rdata_0  out  DATA_WIDTH  port 0 read data.
- rvalid_0  out  1  port 0 read data valid.
- cs_1, wr_1, oe_1, be_1, addr_1, wdata_1, rdata_1, rvalid_1: identical set for port 1.
- collision  out  1  one-cycle pulse: same-address write/write conflict.
- coll_count  out  CNT_WIDTH  saturating count of collision events.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - rdata_0/1 = 0, rvalid_0/1 = 0, collision = 0, coll_count = 0.
  - All in-flight read pipeline stages cleared.
  - Memory array is not cleared; contents hold across reset and are undefined at power-up.
  - No write occurs on any edge while rst is high.
- Write on port p at an edge when cs_p && wr_p:
  - Each byte lane i with be_p[i] = 1 takes wdata_p lane i.
  - Other lanes unchanged.
  - be_p = 0 is a legal no-op write.
  - A port never writes unless its own cs and wr are high.
- Read issue on port p: cs_p && !wr_p && oe_p at edge N.
  - RD_LATENCY = 1: rdata_p = mem[addr_p] and rvalid_p = 1 after edge N.
  - RD_LATENCY = 2: result appears after edge N+1.
  - Back-to-back reads are fully pipelined: one result per cycle.
  - rvalid_p high for exactly one cycle per issued read.
  - rdata_p = 0 whenever rvalid_p = 0.
  - cs_p or oe_p low: no read issued, no rvalid.
- Write/write, same address, same edge:
  - Lanes enabled on both ports take port 0 data.
  - Lanes enabled only on port 1 take port 1 data.
  - Lanes enabled on port 0 only take port 0 data.
  - collision = 1 for the cycle after that edge, only if the enabled lanes overlap.
  - coll_count increments by 1 on each such event and saturates at 2**CNT_WIDTH-1 (no wrap).
- Cross-port read/write, same address, same edge (port a reads, port b writes):
  - RDW_MODE = 0: read returns the pre-write word.
  - RDW_MODE = 1: read returns the post-write word, byte-merged per be_b.
  - No collision is flagged.
- Simultaneous reads of the same address on both ports: both return the same word; no conflict.
- Address range: full 2**ADDR_WIDTH space; no out-of-range case exists.
- Reset mid-read: pending results are discarded; no rvalid is produced for reads issued before or during reset.

Test Plan:
- Reset then idle: rst high 3 cycles, release -> rdata_0/1 = 0, rvalid_0/1 = 0, coll_count = 0.
- Byte-lane write:
  - Port 0 writes 0xAABBCCDD to addr 5 with be = 4'hF.
  - Port 0 writes 0x11223344 to addr 5 with be = 4'b0101.
  - Port 1 then reads addr 5 -> 0xAA22CC44.
  - With RD_LATENCY = 1, rvalid_1 is high one cycle after issue.
- Latency/pipelining, RD_LATENCY = 2:
  - Port 0 issues reads of addr 1, 2, 3 on consecutive edges, holding 0x10, 0x20, 0x30.
  - Required: rvalid_0 high for 3 consecutive cycles starting 2 cycles after the first issue, with data 0x10, 0x20, 0x30.
- Write/write collision on addr 9:
  - Port 0 writes 0x000000FF with be = 4'b0011; port 1 writes 0xFFFF0000 with be = 4'b1111, same edge.
  - mem[9] = 0xFFFF00FF.
  - collision pulses 1 cycle; coll_count = 1.
  - Repeat 300 times with CNT_WIDTH = 8 -> coll_count = 255.
- Read-during-write on addr 7, old value 0x12345678:
  - Port 1 writes 0xCAFEBABE while port 0 reads addr 7.
  - RDW_MODE = 0 -> rdata_0 = 0x12345678; RDW_MODE = 1 -> rdata_0 = 0xCAFEBABE.
  - collision stays 0.
- Reset mid-operation:
  - Issue a port 1 read (RD_LATENCY = 2), then assert rst asynchronously between edges.
  - rvalid_1 and rdata_1 clear immediately, and no rvalid_1 appears after release.
  - A write attempted during reset leaves memory unchanged.
